// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2,
    STORE     = 2'd3
  } sched_state_e;

  localparam logic CH_P1 = 1'b0;
  localparam logic CH_P2 = 1'b1;

endpackage

// File: rtl/adc_scheduler_if.sv
// Request/response handshake between the scheduler (master) and the SPI ADC core (slave).
interface adc_scheduler_if #(
  parameter int DATA_W = 12
);
  logic              conv_req;
  logic              conv_ch;
  logic              conv_done;
  logic [DATA_W-1:0] conv_data;

  modport master (output conv_req, output conv_ch, input conv_done, input conv_data);
  modport slave  (input conv_req, input conv_ch, output conv_done, output conv_data);
endinterface

// File: rtl/sample_tick.sv
// Free-running sample divider: one-cycle tick every DIV cycles while enabled; disabling clears it.
module sample_tick #(
  parameter int DIV = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable && (cnt_q != LAST)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);
endmodule

// File: rtl/adc_scheduler.sv
// Periodic conversion scheduler for the shared 2-channel ADC; ADC_AVG_EN enables per-channel averaging.
// state     | meaning
// IDLE      | waiting for a sample tick; channel latched on tick
// REQ       | first cycle of conv_req; wait counter loaded
// WAIT_DONE | conv_req held until conv_done or wait counter expires
// STORE     | captured result written to p1data/p2data with valid pulse
module adc_scheduler
  import adc_sched_pkg::*;
#(
  parameter int SAMPLE_DIV = 24000,
  parameter int DATA_W     = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode_multi,
  adc_scheduler_if.master   adc,
  output logic [DATA_W-1:0] p1data,
  output logic [DATA_W-1:0] p2data,
  output logic              p1_valid,
  output logic              p2_valid,
  output logic              overrun,
  output logic              timeout_err
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

  sched_state_e      state_q, state_d;
  logic              tick;
  logic              next_ch_q, next_ch_d;
  logic              conv_ch_q, conv_ch_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] p1data_q, p1data_d, p2data_q, p2data_d;
  logic              p1_valid_q, p1_valid_d, p2_valid_q, p2_valid_d;
  logic              overrun_q, overrun_d, timeout_err_q, timeout_err_d;
  logic [DATA_W-1:0] store_val;
`ifdef ADC_AVG_EN
  logic [1:0]        primed_q, primed_d;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W:0]   avg_sum;
`endif

  sample_tick #(.DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      next_ch_q     <= CH_P1;
      conv_ch_q     <= CH_P1;
      wait_cnt_q    <= '0;
      cap_q         <= '0;
      p1data_q      <= '0;
      p2data_q      <= '0;
      p1_valid_q    <= 1'b0;
      p2_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef ADC_AVG_EN
      primed_q      <= 2'b00;
`endif
    end else begin
      state_q       <= state_d;
      next_ch_q     <= next_ch_d;
      conv_ch_q     <= conv_ch_d;
      wait_cnt_q    <= wait_cnt_d;
      cap_q         <= cap_d;
      p1data_q      <= p1data_d;
      p2data_q      <= p2data_d;
      p1_valid_q    <= p1_valid_d;
      p2_valid_q    <= p2_valid_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
`ifdef ADC_AVG_EN
      primed_q      <= primed_d;
`endif
    end
  end

  // conv_done wins over an expiring wait counter in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tick) state_d = REQ;
      REQ:       state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (adc.conv_done)          state_d = STORE;
        else if (wait_cnt_q == '0)  state_d = IDLE;
      end
      STORE:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef ADC_AVG_EN
    old_val   = (conv_ch_q == CH_P1) ? p1data_q : p2data_q;
    avg_sum   = {1'b0, old_val} + {1'b0, cap_q} + (DATA_W + 1)'(1);
    store_val = primed_q[conv_ch_q] ? avg_sum[DATA_W:1] : cap_q;
    primed_d  = primed_q;
`else
    store_val = cap_q;
`endif
    next_ch_d     = next_ch_q;
    conv_ch_d     = conv_ch_q;
    wait_cnt_d    = wait_cnt_q;
    cap_d         = cap_q;
    p1data_d      = p1data_q;
    p2data_d      = p2data_q;
    p1_valid_d    = 1'b0;
    p2_valid_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q | (tick && (state_q != IDLE));
    case (state_q)
      IDLE: if (tick) conv_ch_d = mode_multi ? next_ch_q : CH_P1;
      REQ:  wait_cnt_d = WAIT_LOAD;
      WAIT_DONE: begin
        if (adc.conv_done) begin
          cap_d = adc.conv_data;
        end else if (wait_cnt_q == '0) begin
          timeout_err_d = 1'b1;
          next_ch_d     = mode_multi ? ~conv_ch_q : CH_P1;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      STORE: begin
        if (conv_ch_q == CH_P1) begin
          p1data_d   = store_val;
          p1_valid_d = 1'b1;
        end else begin
          p2data_d   = store_val;
          p2_valid_d = 1'b1;
        end
`ifdef ADC_AVG_EN
        primed_d[conv_ch_q] = 1'b1;
`endif
        next_ch_d = mode_multi ? ~conv_ch_q : CH_P1;
      end
      default: ;
    endcase
  end

  assign adc.conv_req = (state_q == REQ) || (state_q == WAIT_DONE);
  assign adc.conv_ch  = conv_ch_q;
  assign p1data       = p1data_q;
  assign p2data       = p2data_q;
  assign p1_valid     = p1_valid_q;
  assign p2_valid     = p2_valid_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_adc_scheduler.sv
// Bench for adc_scheduler: ADC core model answering after a programmable latency, result scoreboard.
module tb_adc_scheduler;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset, enable, mode_multi;
  logic [DW-1:0] p1data, p2data;
  logic          p1_valid, p2_valid, overrun, timeout_err;

  adc_scheduler_if #(.DATA_W(DW)) adc_bus ();

  adc_scheduler #(.SAMPLE_DIV(4), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode_multi  (mode_multi),
    .adc         (adc_bus),
    .p1data      (p1data),
    .p2data      (p2data),
    .p1_valid    (p1_valid),
    .p2_valid    (p2_valid),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            lat = 2;
  logic [DW-1:0] d0 = '0, d1 = '0;
  int            age = 0;
  bit            answered = 0;
  logic [DW:0]   sb_q[$];
  bit            primed[2];
  logic [DW-1:0] last_val[2];
  logic [DW-1:0] m_val, m_exp, m_got;
  logic [DW:0]   m_sum, m_pop;
  logic          m_ch;
  logic [1:0]    exp_vld;

  bit   mon_en = 0;
  logic req_prev = 1'b0, cur_ch = 1'b0, exp_next = 1'b0, exp_ch;
  int   req_len = 0, last_req_len = 0, req_count = 0, p1v_cnt = 0, p2v_cnt = 0;
  logic ch_log[8];
  int   ch_log_n = 0;

  // ADC core model: one conv_done pulse 'lat' cycles after conv_req rises
  always @(negedge clk) begin
    if (reset !== 1'b1 || adc_bus.conv_req !== 1'b1) begin
      age = 0;
      answered = 0;
      adc_bus.conv_done = 1'b0;
    end else begin
      age++;
      if (!answered && age == lat) begin
        m_ch = adc_bus.conv_ch;
        m_val = m_ch ? d1 : d0;
        adc_bus.conv_data = m_val;
        adc_bus.conv_done = 1'b1;
        answered = 1;
`ifdef ADC_AVG_EN
        if (primed[m_ch]) begin
          m_sum = {1'b0, last_val[m_ch]} + {1'b0, m_val} + 13'd1;
          m_exp = m_sum[DW:1];
        end else begin
          m_exp = m_val;
        end
        primed[m_ch] = 1;
        last_val[m_ch] = m_exp;
`else
        m_exp = m_val;
`endif
        sb_q.push_back({m_ch, m_exp});
      end else begin
        adc_bus.conv_done = 1'b0;
      end
    end
  end

  // request/channel monitor and result scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (adc_bus.conv_req === 1'b1 && req_prev !== 1'b1) begin
        exp_ch = mode_multi ? exp_next : 1'b0;
        checks++;
        if (adc_bus.conv_ch !== exp_ch) begin
          errors++;
          $display("FAIL conv_ch_at_req: got %0b expected %0b", adc_bus.conv_ch, exp_ch);
        end
        cur_ch = exp_ch;
        req_len = 1;
        req_count++;
        if (ch_log_n < 8) begin
          ch_log[ch_log_n] = adc_bus.conv_ch;
          ch_log_n++;
        end
      end else if (adc_bus.conv_req === 1'b1) begin
        req_len++;
        checks++;
        if (adc_bus.conv_ch !== cur_ch) begin
          errors++;
          $display("FAIL conv_ch_stable: got %0b expected %0b", adc_bus.conv_ch, cur_ch);
        end
      end else if (req_prev === 1'b1) begin
        last_req_len = req_len;
        exp_next = mode_multi ? ~cur_ch : 1'b0;
      end
      req_prev = adc_bus.conv_req;

      if (p1_valid === 1'b1 || p2_valid === 1'b1) begin
        if (p1_valid === 1'b1) p1v_cnt++;
        if (p2_valid === 1'b1) p2v_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: p1_valid=%0b p2_valid=%0b with no result outstanding",
                   p1_valid, p2_valid);
        end else begin
          m_pop = sb_q.pop_front();
          exp_vld = m_pop[DW] ? 2'b10 : 2'b01;
          if ({p2_valid, p1_valid} !== exp_vld) begin
            errors++;
            $display("FAIL valid_select: {p2,p1}_valid=%b expected %b", {p2_valid, p1_valid}, exp_vld);
          end
          checks++;
          m_got = m_pop[DW] ? p2data : p1data;
          if (m_got !== m_pop[DW-1:0]) begin
            errors++;
            $display("FAIL stored_data: ch%0d got 0x%03h expected 0x%03h", m_pop[DW], m_got, m_pop[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    mon_en = 0;
    enable = 1'b0;
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    primed[0] = 0;
    primed[1] = 0;
    exp_next = 1'b0;
    req_prev = 1'b0;
    req_count = 0;
    p1v_cnt = 0;
    p2v_cnt = 0;
    ch_log_n = 0;
    last_req_len = 0;
    mon_en = 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (adc_bus.conv_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_conv_req: cycle %0d got %b expected 0", i, adc_bus.conv_req);
      end
    end
    checks++;
    if ({p1data, p2data} !== '0) begin
      errors++;
      $display("FAIL reset_data: p1data=0x%03h p2data=0x%03h expected 0", p1data, p2data);
    end
    checks++;
    if ({p1_valid, p2_valid, overrun, timeout_err, adc_bus.conv_ch} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: {p1v,p2v,ovr,tmo,ch}=%b expected 00000",
               {p1_valid, p2_valid, overrun, timeout_err, adc_bus.conv_ch});
    end
  endtask

  task automatic test_single();
    apply_reset(2);
    mode_multi = 1'b0; lat = 2; d0 = 12'h3A5; d1 = 12'h155;
    enable = 1'b1;
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (p1data !== 12'h3A5) begin errors++; $display("FAIL single_p1data: got 0x%03h expected 0x3a5", p1data); end
    checks++;
    if (p1v_cnt < 5 || p2v_cnt != 0) begin
      errors++; $display("FAIL single_valids: p1 pulses %0d (need >=5) p2 pulses %0d (need 0)", p1v_cnt, p2v_cnt);
    end
    checks++;
    if (p2data !== '0) begin errors++; $display("FAIL single_p2data: got 0x%03h expected 0", p2data); end
    checks++;
    if (req_count != p1v_cnt || sb_q.size() != 0) begin
      errors++; $display("FAIL single_requests: requests %0d results %0d pending %0d", req_count, p1v_cnt, sb_q.size());
    end
    checks++;
    if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL single_flags: overrun=%b timeout_err=%b expected 0 0", overrun, timeout_err);
    end
  endtask

  task automatic test_multi();
    logic exp_c;
    apply_reset(1);
    mode_multi = 1'b1; lat = 2; d0 = 12'h100; d1 = 12'h200;
    enable = 1'b1;
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 1);
      checks++;
      if (ch_log[i] !== exp_c) begin
        errors++; $display("FAIL multi_ch_seq: request %0d got %b expected %b", i, ch_log[i], exp_c);
      end
    end
    checks++;
    if (p1data !== 12'h100 || p2data !== 12'h200) begin
      errors++; $display("FAIL multi_data: p1data=0x%03h p2data=0x%03h expected 0x100 0x200", p1data, p2data);
    end
    checks++;
    if (req_count != p1v_cnt + p2v_cnt || p1v_cnt == 0 || p2v_cnt == 0) begin
      errors++; $display("FAIL multi_counts: requests %0d p1 %0d p2 %0d", req_count, p1v_cnt, p2v_cnt);
    end
    mode_multi = 1'b0;
  endtask

  task automatic test_overrun();
    apply_reset(1);
    mode_multi = 1'b0; lat = 6; d0 = 12'h2C7;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial: got %b expected 0", overrun); end
    enable = 1'b1;
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    checks++;
    if (req_count != p1v_cnt || p1v_cnt == 0 || sb_q.size() != 0) begin
      errors++; $display("FAIL overrun_requests: requests %0d results %0d pending %0d", req_count, p1v_cnt, sb_q.size());
    end
    checks++;
    if (p1data !== 12'h2C7 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL overrun_data: p1data=0x%03h timeout_err=%b expected 0x2c7 0", p1data, timeout_err);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    apply_reset(1);
    mode_multi = 1'b0; lat = 1000;
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (timeout_err === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_flag: timeout_err still %b after 60 cycles, expected 1", timeout_err); end
    @(posedge clk); #1;
    checks++;
    if (last_req_len != 9) begin
      errors++; $display("FAIL timeout_req_len: conv_req high %0d cycles expected 9", last_req_len);
    end
    enable = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (p1data !== '0 || p1v_cnt != 0 || timeout_err !== 1'b1 || adc_bus.conv_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: p1data=0x%03h valids=%0d timeout_err=%b conv_req=%b expected 0 0 1 0",
               p1data, p1v_cnt, timeout_err, adc_bus.conv_req);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    apply_reset(1);
    mode_multi = 1'b0; lat = 1000;
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (adc_bus.conv_req === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midwait_req: conv_req never rose, got %b expected 1", adc_bus.conv_req); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (adc_bus.conv_req !== 1'b0 || timeout_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset: conv_req=%b timeout_err=%b overrun=%b expected 0 0 0",
               adc_bus.conv_req, timeout_err, overrun);
    end
    apply_reset(1);
  endtask

  task automatic test_avg();
    bit seen;
    logic [DW-1:0] exp2, exp3;
`ifdef ADC_AVG_EN
    exp2 = 12'h800;
    exp3 = 12'hC00;
`else
    exp2 = 12'hFFF;
    exp3 = 12'hFFF;
`endif
    apply_reset(1);
    mode_multi = 1'b0; lat = 2; d0 = 12'h000;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (p1_valid === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL avg_valid: sample %0d no p1_valid within 20 cycles", k); end
      d0 = 12'hFFF;
      checks++;
      if (k == 0 && p1data !== 12'h000) begin
        errors++; $display("FAIL avg_first: got 0x%03h expected 0x000", p1data);
      end else if (k == 1 && p1data !== exp2) begin
        errors++; $display("FAIL avg_second: got 0x%03h expected 0x%03h", p1data, exp2);
      end else if (k == 2 && p1data !== exp3) begin
        errors++; $display("FAIL avg_third: got 0x%03h expected 0x%03h", p1data, exp3);
      end
    end
    #1 enable = 1'b0;
    repeat (15) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    mode_multi = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_overrun();
    test_timeout();
    test_reset_mid_wait();
    test_avg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
